// File: rtl/i2s_pkg.sv
// Shared defaults, state encoding and word-select helper for the I2S transmitter.
package i2s_pkg;

    localparam int unsigned SW_DEF  = 16;
    localparam int unsigned DIV_DEF = 4;
    localparam int unsigned DW_DEF  = 2 * SW_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Word select for frame position p: high for the right-channel slots,
    // shifted one SCK early relative to the channel MSB.
    function automatic logic ws_at(input int unsigned p, input int unsigned sw);
        return (p >= sw - 1) && (p <= 2 * sw - 2);
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider: sck toggles every DIV clk cycles while run is high,
// fall_tick flags the cycle whose closing edge drives sck from 1 to 0.
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sck,
    output logic fall_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          wrap_c;

    // Half-period counter; held cleared with sck low when not running.
    always_comb begin
        wrap_c = (cnt_q == CW'(DIV - 1));
        cnt_d  = cnt_q;
        sck_d  = sck_q;
        if (!run) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (wrap_c) begin
            cnt_d = '0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck       = sck_q;
    assign fall_tick = run && wrap_c && sck_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: pops one {left,right} word per frame from a show-ahead FIFO
// and serialises it MSB first with a one-SCK word-select lead.
// Build option: define I2S_TX_REPEAT_EN to replay the last fetched word on
// underrun instead of sending zeros.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned SW  = SW_DEF,
    parameter int unsigned DIV = DIV_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          empty,
    input  logic [DW-1:0] rdt,
    output logic          ren,
    output logic          sck,
    output logic          ws,
    output logic          sd,
    output logic          underrun
);

    localparam int unsigned    PW     = $clog2(2 * SW);
    localparam logic [PW-1:0]  P_LAST = PW'(2 * SW - 1);

    if (DW != 2 * SW) begin : g_dw_check
        $error("i2s_tx: DW must equal 2*SW");
    end

    state_e        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [DW-1:0] sr_q, sr_d;
    logic          sd_q, sd_d;
    logic          ws_q, ws_d;
    logic          ren_q, ren_d;
    logic          uf_q, uf_d;
    logic          fall_tick;
    logic [DW-1:0] sub_c;
    logic [DW-1:0] word_c;
    logic [PW-1:0] p_nx_c;

`ifdef I2S_TX_REPEAT_EN
    logic [DW-1:0] last_q, last_d;
`endif

    i2s_sck_gen #(
        .DIV (DIV)
    ) u_sck_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state_q == RUN),
        .sck       (sck),
        .fall_tick (fall_tick)
    );

    // Frame sequencing: start/stop at the frame boundary, fetch, shift, ws.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        sr_d    = sr_q;
        sd_d    = sd_q;
        ws_d    = ws_q;
        ren_d   = 1'b0;
        uf_d    = 1'b0;
        p_nx_c  = (p_q == P_LAST) ? '0 : p_q + PW'(1);
`ifdef I2S_TX_REPEAT_EN
        last_d  = last_q;
        sub_c   = last_q;
`else
        sub_c   = '0;
`endif
        word_c  = empty ? sub_c : rdt;

        case (state_q)
            IDLE: begin
                p_d  = '0;
                sd_d = 1'b0;
                ws_d = 1'b0;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fall_tick) begin
                    if (p_q == '0) begin
                        if (!en) begin
                            state_d = IDLE;
                            sd_d    = 1'b0;
                            ws_d    = 1'b0;
                        end else begin
                            ren_d = !empty;
                            uf_d  = empty;
                            sd_d  = word_c[DW-1];
                            sr_d  = {word_c[DW-2:0], 1'b0};
                            p_d   = PW'(1);
                            ws_d  = ws_at(32'd1, SW);
`ifdef I2S_TX_REPEAT_EN
                            if (!empty) begin
                                last_d = rdt;
                            end
`endif
                        end
                    end else begin
                        sd_d = sr_q[DW-1];
                        sr_d = {sr_q[DW-2:0], 1'b0};
                        p_d  = p_nx_c;
                        ws_d = ws_at(32'(p_nx_c), SW);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transmitter state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            sr_q    <= '0;
            sd_q    <= 1'b0;
            ws_q    <= 1'b0;
            ren_q   <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            sr_q    <= sr_d;
            sd_q    <= sd_d;
            ws_q    <= ws_d;
            ren_q   <= ren_d;
            uf_q    <= uf_d;
        end
    end

`ifdef I2S_TX_REPEAT_EN
    // Last successfully fetched word, replayed on underrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign ren      = ren_q;
    assign ws       = ws_q;
    assign sd       = sd_q;
    assign underrun = uf_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus queues expected frames, a negedge
// monitor deserialises sd per frame and compares against the queue.
module tb_i2s_tx;

    localparam int unsigned SW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned DIV = 2;

    typedef struct {
        logic [DW-1:0] word;
        logic          uf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          empty;
    logic [DW-1:0] rdt;
    logic          ren, sck, ws, sd, underrun;

    int tests = 0;
    int fails = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] fifo[$];
    int            ren_times[$];
    logic [DW-1:0] last_word = '0;

    int cyc = 0;
    int fetch_cnt = 0, frames_done = 0, ren_cnt = 0, uf_cnt = 0, mon_p = 0;
    int ws_err = 0, intv_err = 0, chg_err = 0, pulse_err = 0, ren_empty_err = 0;

    bit            in_frame = 0, fall;
    bit            prev_sck = 0, prev_sd = 0, prev_ws = 0, prev_ren = 0, prev_uf = 0;
    int            bitcnt = 0, last_fall = 0;
    logic [DW-1:0] sh;
    logic          frame_uf;

    i2s_tx #(.DW(DW), .SW(SW), .DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .empty    (empty),
        .rdt      (rdt),
        .ren      (ren),
        .sck      (sck),
        .ws       (ws),
        .sd       (sd),
        .underrun (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic refresh();
        empty = (fifo.size() == 0);
        rdt   = empty ? '0 : fifo[0];
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        exp_t e;
        e.word = w;
        e.uf   = 1'b0;
        fifo.push_back(w);
        exp_q.push_back(e);
        last_word = w;
        refresh();
    endtask

    function automatic bit reached(input int which, input int target);
        case (which)
            0:       return fetch_cnt >= target;
            1:       return frames_done >= target;
            default: return mon_p == target;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input string name);
        bit ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (reached(which, target)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL timeout_%s: target %0d not reached in 20000 cycles", name, target);
        end
    endtask

    // Edges from the en/reset-release slot until ren is seen.
    task automatic measure_latency(input string name);
        int n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (ren) begin
                n = i;
                break;
            end
        end
        check(name, 32'(n), 32'(2 * DIV + 1));
    endtask

    // Monitor: FIFO pop model, frame deserialiser and protocol checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0;
            prev_sck = 0; prev_sd = 0; prev_ws = 0; prev_ren = 0; prev_uf = 0;
            bitcnt   = 0;
            mon_p    = 0;
        end else begin
            fall = prev_sck && !sck;
            if ((ren || underrun) && !fall) pulse_err++;
            if ((ren && prev_ren) || (underrun && prev_uf) || (ren && underrun)) pulse_err++;
            if (!fall && (sd !== prev_sd || ws !== prev_ws)) chg_err++;
            if (ren) begin
                ren_cnt++;
                ren_times.push_back(cyc);
                if (fifo.size() == 0) ren_empty_err++;
                else begin
                    void'(fifo.pop_front());
                    refresh();
                end
            end
            if (underrun) uf_cnt++;
            if (fall) begin
                if (ren || underrun) begin
                    in_frame = 1;
                    bitcnt   = 1;
                    mon_p    = 1;
                    sh       = {{(DW-1){1'b0}}, sd};
                    frame_uf = underrun;
                    fetch_cnt++;
                    if (ws !== 1'b0) ws_err++;
                end else if (in_frame) begin
                    if (cyc - last_fall != int'(2 * DIV)) intv_err++;
                    bitcnt++;
                    mon_p = bitcnt % int'(2 * SW);
                    sh    = {sh[DW-2:0], sd};
                    if (ws !== ((mon_p >= int'(SW) - 1) && (mon_p <= 2 * int'(SW) - 2))) ws_err++;
                    if (bitcnt == int'(2 * SW)) begin
                        in_frame = 0;
                        frames_done++;
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL frame_word: got %h expected none queued", sh);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("frame_word", sh, e.word);
                            check("frame_underrun", 32'(frame_uf), 32'(e.uf));
                        end
                    end
                end
                last_fall = cyc;
            end
            prev_sck = sck; prev_sd = sd; prev_ws = ws; prev_ren = ren; prev_uf = underrun;
        end
    end

    initial begin
        exp_t eu;
        int   n0;
        int   idle_err;
        rst_n = 1'b0;
        en    = 1'b0;
        refresh();

        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {27'b0, sck, ws, sd, ren, underrun}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("idle_outputs", {27'b0, sck, ws, sd, ren, underrun}, 32'd0);

        // First frame and start latency.
        push_word(32'hA5A5_0F0F);
        en = 1'b1;
        measure_latency("start_latency");
        push_word(32'h1234_5678);

        // Underrun on the third fetch.
        wait_for(0, 2, "fetch2");
`ifdef I2S_TX_REPEAT_EN
        eu.word = last_word;
`else
        eu.word = '0;
`endif
        eu.uf = 1'b1;
        exp_q.push_back(eu);
        wait_for(0, 3, "fetch3");
        check("underrun_count", 32'(uf_cnt), 32'd1);

        // Three words back to back.
        n0 = ren_times.size();
        push_word(32'hDEAD_BEEF);
        push_word(32'h0123_4567);
        push_word(32'hFFFF_0000);
        wait_for(0, 6, "fetch6");
        check("b2b_ren_count", 32'(ren_times.size() - n0), 32'd3);
        if (ren_times.size() >= n0 + 3) begin
            check("b2b_gap1", 32'(ren_times[n0+1] - ren_times[n0]), 32'(4 * SW * DIV));
            check("b2b_gap2", 32'(ren_times[n0+2] - ren_times[n0+1]), 32'(4 * SW * DIV));
        end

        // Stop at p=7 with a word still waiting in the FIFO.
        push_word(32'h8001_7FFE);
        wait_for(2, 7, "p7");
        en = 1'b0;
        wait_for(1, 6, "frame6");
        repeat (2 * DIV + 2) @(posedge clk);
        #1 check("stop_outputs", {29'b0, sck, ws, sd}, 32'd0);
        idle_err = 0;
        for (int i = 0; i < int'(8 * DIV); i++) begin
            @(posedge clk); #1;
            if (sck || ren || underrun) idle_err++;
        end
        check("stop_idle", 32'(idle_err), 32'd0);
        check("stop_ren_count", 32'(ren_cnt), 32'd5);
        check("stop_fifo_level", 32'(fifo.size()), 32'd1);

        // Restart, then reset at p=20.
        en = 1'b1;
        measure_latency("restart_latency");
        wait_for(2, 20, "p20");
        rst_n = 1'b0;
        #1 check("async_reset_outputs", {27'b0, sck, ws, sd, ren, underrun}, 32'd0);
        void'(exp_q.pop_front());
        push_word(32'hC3C3_5A5A);
        repeat (3) @(posedge clk);
        #1 check("reset_hold_outputs", {27'b0, sck, ws, sd, ren, underrun}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        measure_latency("reset_release_latency");
        en = 1'b0;
        wait_for(1, 7, "frame7");
        repeat (4 * DIV) @(posedge clk);

        #1;
        check("final_exp_queue", 32'(exp_q.size()), 32'd0);
        check("final_fifo_level", 32'(fifo.size()), 32'd0);
        check("final_ren_count", 32'(ren_cnt), 32'd7);
        check("final_underrun_count", 32'(uf_cnt), 32'd1);
        check("ws_timing", 32'(ws_err), 32'd0);
        check("sck_interval", 32'(intv_err), 32'd0);
        check("change_off_tick", 32'(chg_err), 32'd0);
        check("pulse_shape", 32'(pulse_err), 32'd0);
        check("ren_while_empty", 32'(ren_empty_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DW, default 32: width of the FIFO word, carrying {left[SW-1:0], right[SW-1:0]}; SHALL equal 2*SW.
REQ-002 Parameter SW, default 16: bits per channel sample.
REQ-003 Parameter DIV, default 4: clk cycles per SCK half-period; legal range is DIV >= 1.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port en, input, 1: run request, sampled at frame boundaries.
REQ-007 Port empty, input, 1: FIFO empty flag.
REQ-008 Port rdt, input, DW: FIFO show-ahead read data, valid whenever empty=0.
REQ-009 Port ren, output, 1: FIFO pop, a one-clk pulse.
REQ-010 Port sck, output, 1: I2S bit clock.
REQ-011 Port ws, output, 1: word select; 0 selects left, 1 selects right.
REQ-012 Port sd, output, 1: serial data, MSB first.
REQ-013 Port underrun, output, 1: one-clk pulse when a fetch finds the FIFO empty.

Function
REQ-014 Divider: in RUN, sck SHALL toggle every DIV clk cycles; a "fall tick" is the clk cycle in which sck goes from 1 to 0.
REQ-015 States:
- IDLE: sck=0, ws=0, sd=0, position p=0.
- RUN: active transmission.
REQ-016 IDLE->RUN when en=1; the first sck rise SHALL occur DIV cycles later, and the first fall tick 2*DIV cycles later.
REQ-017 Position p SHALL count fall ticks modulo 2*SW; each fall tick advances p.
REQ-018 WS timing: ws SHALL be 0 for p in {2SW-1, 0..SW-2} and 1 for p in {SW-1..2SW-2}, so ws leads the channel MSB by one SCK (I2S delay).
REQ-019 Fetch: on the fall tick entering p=1, ren SHALL pulse for that clk cycle if empty=0, and rdt SHALL be loaded into the 2*SW shift register.
REQ-020 Serial data: sd SHALL present word bit (2SW-p) during p=1..2SW-1 and bit 0 during the following p=0. sd changes only on fall ticks.
REQ-021 Underrun: if empty=1 at a fetch tick, ren SHALL stay 0, underrun SHALL pulse for one clk, and the substitute word per REQ-027 SHALL be loaded.
REQ-022 ren SHALL never assert while empty=1, and SHALL assert at most once per frame.
REQ-023 Stop: if en=0 on the fall tick that would enter p=1, the block SHALL return to IDLE with no fetch and no underrun. A frame, once started, always completes.
REQ-024 Toggling en mid-frame SHALL have no effect before the frame boundary.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and all of the following to 0: sck, ws, sd, ren, underrun, divider, p, shift register, and last-sample register.
REQ-026 Assertion of rst_n mid-frame SHALL abort the frame with no further ren; release SHALL be synchronous-safe, with no state change in the release cycle other than IDLE->RUN per REQ-016.

Configuration
REQ-027 Macro I2S_TX_REPEAT_EN:
- Defined: the underrun substitute word SHALL be the last successfully fetched word (0 if none since reset).
- Undefined: the substitute word SHALL be all zeros, and no last-sample register SHALL be synthesized.

Structure
REQ-028 Shared package i2s_pkg SHALL hold the defaults for SW, DIV and DW, and the state enum (IDLE, RUN).
REQ-029 The divider SHALL be a sub-module i2s_sck_gen with outputs sck and fall_tick; everything else lives in i2s_tx.

Verification
REQ-030 SW=16, DIV=2, FIFO word 0xA5A50F0F, en=1: ren pulses once; sd across p=1..31,0 = 1010010110100101 then 0000111100001111; sck period is 4 clk.
REQ-031 ws check: ws falls at the fall tick entering p=31 and rises at the fall tick entering p=15; left MSB appears at p=1.
REQ-032 empty=1 at fetch: underrun=1 for 1 clk and ren=0. Without the macro, sd is 0 for the whole frame; with I2S_TX_REPEAT_EN after a prior fetch of 0x12345678, sd replays 0x12345678.
REQ-033 Back-to-back: 3 words queued: exactly 3 ren pulses, spaced 64*DIV clk apart, with gapless serial output.
REQ-034 en dropped at p=7: the frame completes through p=0, then IDLE with sck=0, ws=0, sd=0 and no extra ren.
REQ-035 rst_n pulsed low at p=20: all outputs are 0 within the same cycle; after release with en=1, the first ren occurs at the fall tick entering p=1, 2*DIV cycles after restart.
